// File: rtl/snake_pkg.sv
// Shared types and default geometry for the snake body tracker.
package snake_pkg;

   localparam int unsigned GRID_W_DEF   = 16;
   localparam int unsigned GRID_H_DEF   = 8;
   localparam int unsigned COORD_W_DEF  = 4;
   localparam int unsigned MAX_LEN_DEF  = 50;
   localparam int unsigned INIT_LEN_DEF = 3;
   localparam int unsigned LEN_W        = 7;

   typedef logic [COORD_W_DEF-1:0] coord_t;

   // One-hot move direction, bit order {up,down,left,right}.
   typedef enum logic [3:0] {
      DIR_RIGHT = 4'b0001,
      DIR_LEFT  = 4'b0010,
      DIR_DOWN  = 4'b0100,
      DIR_UP    = 4'b1000
   } dir_t;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SCAN,
      COMMIT,
      DEAD
   } state_t;

   function automatic dir_t opposite(input dir_t d);
      case (d)
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         DIR_LEFT:  return DIR_RIGHT;
         default:   return DIR_LEFT;
      endcase
   endfunction

endpackage

// File: rtl/snake_body_tracker_segment_store.sv
// Body segment shift register: head at index 0, shifts toward the tail on commit.
module segment_store #(
   parameter int unsigned GRID_W  = 16,
   parameter int unsigned GRID_H  = 8,
   parameter int unsigned COORD_W = 4,
   parameter int unsigned MAX_LEN = 50,
   parameter int unsigned IDX_W   = 6
) (
   input  logic               clk,
   input  logic               init,
   input  logic               shift,
   input  logic [COORD_W-1:0] new_x,
   input  logic [COORD_W-1:0] new_y,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [COORD_W-1:0] rd_x,
   output logic [COORD_W-1:0] rd_y,
   output logic [COORD_W-1:0] head_x,
   output logic [COORD_W-1:0] head_y
);

   logic [COORD_W-1:0] seg_x [MAX_LEN];
   logic [COORD_W-1:0] seg_y [MAX_LEN];

   // Init lays the body out as a horizontal line trailing left of centre.
   always_ff @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            seg_x[i] <= COORD_W'(GRID_W / 2 - i);
            seg_y[i] <= COORD_W'(GRID_H / 2);
         end
      end else if (shift) begin
         for (int i = int'(MAX_LEN) - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
         end
         seg_x[0] <= new_x;
         seg_y[0] <= new_y;
      end
   end

   always_comb begin
      rd_x = '0;
      rd_y = '0;
      if (32'(rd_idx) < MAX_LEN) begin
         rd_x = seg_x[rd_idx];
         rd_y = seg_y[rd_idx];
      end
   end

   assign head_x = seg_x[0];
   assign head_y = seg_y[0];

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body owner: turns move ticks into wall/self-hit and apple-eaten pulses.
module snake_body_tracker
   import snake_pkg::*;
#(
   parameter int unsigned GRID_W   = GRID_W_DEF,
   parameter int unsigned GRID_H   = GRID_H_DEF,
   parameter int unsigned COORD_W  = COORD_W_DEF,
   parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
   parameter int unsigned INIT_LEN = INIT_LEN_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               step,
   input  logic               restart,
   input  logic [3:0]         direction,
   input  logic [COORD_W-1:0] apple_x,
   input  logic [COORD_W-1:0] apple_y,
   output logic               goodColl,
   output logic               badColl,
   output logic [COORD_W-1:0] head_x,
   output logic [COORD_W-1:0] head_y,
   output logic [LEN_W-1:0]   length,
   output logic               busy,
   output logic               dead
);

   localparam int unsigned IDX_W = $clog2(MAX_LEN);

   state_t             state, state_nx;
   dir_t               cur_dir, cur_dir_nx;
   logic [COORD_W-1:0] nxt_x, nxt_y, nxt_x_nx, nxt_y_nx;
   logic [COORD_W-1:0] cand_x, cand_y;
   logic [COORD_W-1:0] rd_x, rd_y;
   logic [IDX_W-1:0]   idx, idx_nx, lim, lim_nx;
   logic [LEN_W-1:0]   length_nx;
   logic               eat, eat_nx;
   logic               wall_c, seg_shift_c, seg_init_c;
   logic               good_nx, bad_nx, busy_nx, dead_nx;

   assign seg_init_c = rst | restart;

   segment_store #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .COORD_W(COORD_W),
      .MAX_LEN(MAX_LEN),
      .IDX_W  (IDX_W)
   ) u_store (
      .clk   (clk),
      .init  (seg_init_c),
      .shift (seg_shift_c),
      .new_x (nxt_x),
      .new_y (nxt_y),
      .rd_idx(idx),
      .rd_x  (rd_x),
      .rd_y  (rd_y),
      .head_x(head_x),
      .head_y(head_y)
   );

   // Candidate head and wall test; range checked before the coordinate wraps.
   always_comb begin
      cand_x = head_x;
      cand_y = head_y;
      wall_c = 1'b0;
      case (cur_dir)
         DIR_UP: begin
            wall_c = (head_y == '0);
            cand_y = head_y - COORD_W'(1);
         end
         DIR_DOWN: begin
            wall_c = (32'(head_y) + 32'd1 >= GRID_H);
            cand_y = head_y + COORD_W'(1);
         end
         DIR_LEFT: begin
            wall_c = (head_x == '0);
            cand_x = head_x - COORD_W'(1);
         end
         default: begin
            wall_c = (32'(head_x) + 32'd1 >= GRID_W);
            cand_x = head_x + COORD_W'(1);
         end
      endcase
   end

   always_comb begin
      state_nx    = state;
      cur_dir_nx  = cur_dir;
      nxt_x_nx    = nxt_x;
      nxt_y_nx    = nxt_y;
      eat_nx      = eat;
      idx_nx      = idx;
      lim_nx      = lim;
      length_nx   = length;
      good_nx     = 1'b0;
      bad_nx      = 1'b0;
      seg_shift_c = 1'b0;
      case (state)
         IDLE: begin
            if (step) begin
               state_nx = CHECK;
               if ($onehot(direction) && (direction != opposite(cur_dir)))
                  cur_dir_nx = dir_t'(direction);
            end
         end
         CHECK: begin
            if (wall_c) begin
               bad_nx   = 1'b1;
               state_nx = DEAD;
            end else begin
               nxt_x_nx = cand_x;
               nxt_y_nx = cand_y;
               eat_nx   = (cand_x == apple_x) && (cand_y == apple_y);
               // Tail is skipped when not eating because it moves out this step.
               lim_nx   = eat_nx ? IDX_W'(length - LEN_W'(1)) : IDX_W'(length - LEN_W'(2));
               idx_nx   = '0;
               state_nx = SCAN;
            end
         end
         SCAN: begin
            if ((rd_x == nxt_x) && (rd_y == nxt_y)) begin
               bad_nx   = 1'b1;
               state_nx = DEAD;
            end else if (idx == lim) begin
               state_nx = COMMIT;
            end else begin
               idx_nx = idx + IDX_W'(1);
            end
         end
         COMMIT: begin
            seg_shift_c = 1'b1;
            good_nx     = eat;
            if (eat && (length < LEN_W'(MAX_LEN)))
               length_nx = length + LEN_W'(1);
            state_nx = IDLE;
         end
         DEAD: ;
         default: state_nx = IDLE;
      endcase
      if (restart) begin
         state_nx    = IDLE;
         cur_dir_nx  = DIR_RIGHT;
         length_nx   = LEN_W'(INIT_LEN);
         good_nx     = 1'b0;
         bad_nx      = 1'b0;
         seg_shift_c = 1'b0;
      end
      busy_nx = (state_nx == CHECK) || (state_nx == SCAN) || (state_nx == COMMIT);
      dead_nx = (state_nx == DEAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur_dir  <= DIR_RIGHT;
         nxt_x    <= '0;
         nxt_y    <= '0;
         eat      <= 1'b0;
         idx      <= '0;
         lim      <= '0;
         length   <= LEN_W'(INIT_LEN);
         goodColl <= 1'b0;
         badColl  <= 1'b0;
         busy     <= 1'b0;
         dead     <= 1'b0;
      end else begin
         state    <= state_nx;
         cur_dir  <= cur_dir_nx;
         nxt_x    <= nxt_x_nx;
         nxt_y    <= nxt_y_nx;
         eat      <= eat_nx;
         idx      <= idx_nx;
         lim      <= lim_nx;
         length   <= length_nx;
         goodColl <= good_nx;
         badColl  <= bad_nx;
         busy     <= busy_nx;
         dead     <= dead_nx;
      end
   end

endmodule

// File: doc/snake_body_tracker.md
Name: snake_body_tracker

Overview:
- Upstream neighbour of the score tracker: owns the snake body and turns move ticks into one-cycle goodColl/badColl pulses.
- Those pulses feed score_tracker's goodColl/badColl inputs directly.
- On each step it computes the next head from the direction, checks walls, scans body segments for self-collision one per cycle, then commits the move (growing on apple).
- Exposes head position and length for the renderer and apple placer.

Parameters:
GRID_W, 16, grid columns; x in 0..GRID_W-1
GRID_H, 8, grid rows; y in 0..GRID_H-1, y=0 top
COORD_W, 4, coordinate width (>= clog2 of max(GRID_W, GRID_H))
MAX_LEN, 50, segment capacity including head
INIT_LEN, 3, length after reset/restart (2..MAX_LEN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
step  in  1  one-cycle move tick
restart  in  1  one-cycle pulse; reinitialise after game over
direction  in  4  one-hot {up,down,left,right} = bits [3:0]
apple_x  in  COORD_W  apple column
apple_y  in  COORD_W  apple row
goodColl  out  1  one-cycle pulse: apple eaten
badColl  out  1  one-cycle pulse: wall or self hit
head_x  out  COORD_W  current head column
head_y  out  COORD_W  current head row
length  out  7  current segment count
busy  out  1  move in progress
dead  out  1  game over, moves frozen

Behaviour:
- Reset/restart state:
  - seg[0] = (GRID_W/2, GRID_H/2); seg[i] = (GRID_W/2 - i, GRID_H/2); cur_dir = right.
  - length = INIT_LEN; goodColl = badColl = busy = dead = 0; FSM = IDLE.
  - restart wins over step in the same cycle.
- Direction latch (IDLE only):
  - Zero or multi-hot direction keeps cur_dir.
  - A direct reversal of cur_dir keeps cur_dir.
  - Otherwise cur_dir = direction.
- FSM:
  - IDLE: on step, latch direction, go to CHECK. Steps arriving outside IDLE are dropped, not queued.
  - CHECK (1 cycle):
    - Compute nxt = seg[0] + delta (up y-1, down y+1, left x-1, right x+1).
    - Out of range (underflow wrap or >= GRID) -> badColl registered high for the next cycle, go to DEAD.
    - Else eat = (nxt == apple); lim = eat ? length-1 : length-2; idx = 0; go to SCAN.
  - SCAN (one segment per cycle): compare nxt with seg[idx] for idx in 0..lim.
    - Match -> badColl pulse next cycle, go to DEAD (early exit).
    - idx == lim with no match -> COMMIT.
    - The tail is excluded when not eating because it vacates.
  - COMMIT (1 cycle): seg[i] <= seg[i-1], seg[0] <= nxt.
    - If eat: goodColl pulses next cycle; length <= min(length+1, MAX_LEN); old tail retained.
    - At MAX_LEN, goodColl still pulses and length saturates.
    - Go to IDLE.
  - DEAD: dead = 1; segments, head and length frozen; step ignored; restart -> reinitialise.
- Timing:
  - busy = 1 in CHECK, SCAN and COMMIT.
  - Head/length update at the COMMIT edge, coincident with goodColl.
  - Latency from step edge to commit = 2 + (lim+1) cycles.
- Pulses: goodColl and badColl are never high together and never high for more than one cycle.
- apple_x/apple_y are sampled only in CHECK.

Decomposition:
- snake_pkg holds:
  - dir_t with one-hot encodings.
  - coord_t.
  - state_t {IDLE, CHECK, SCAN, COMMIT, DEAD}.
  - Default GRID_W, GRID_H, MAX_LEN constants.
- One sub-module, segment_store:
  - MAX_LEN x 2 x COORD_W shift register with reset-to-initial-line.
  - Indexed read port seg[idx] and shift-in of the new head.

Test Plan:
- Reset, apple (15,0), step right -> after 5 cycles head (9,4), length 3, no pulses; busy high exactly 4 cycles.
- Apple (9,4), step right from reset -> goodColl one cycle at the commit edge, length 4, segs (9,4),(8,4),(7,4),(6,4).
- Step right repeatedly from reset with apple off-path -> after the head reaches (15,4), the next step gives one badColl, dead = 1, head stays (15,4).
  - Further steps produce nothing.
  - restart + step same cycle -> initial state, no move.
- Reversal: heading right, step with direction = left -> head x+1. Step with direction = 4'b0110 -> head x+1.
- Self-hit, length 5 heading right at (h,4):
  - up, left, down -> third move hits seg[3]: badColl, dead.
  - Same sequence at length 4 enters the vacating tail: no badColl, head (h-1,4).
- Saturation: force length 50, eat apple -> goodColl pulses, length stays 50.
